// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control logic.
// Memory-wait FSM state encoding and default timeout live here.
package arm_pipe_pkg;

   typedef enum logic [1:0] {
      M_IDLE,
      M_WAIT,
      M_ERROR
   } mem_state_t;

   localparam int unsigned REG_W           = 4;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check for one ID-stage source operand against the
// in-flight EXE and MEM writebacks.
module hazard_detect
   import arm_pipe_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             use_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             forward_en,
   output logic             hazard
);

   logic exe_hit;
   logic mem_hit;

   always_comb begin
      // A load result cannot be forwarded out of EXE, so it stalls even with forwarding on.
      exe_hit = exe_wb_en & (src == exe_dest) & (~forward_en | exe_mem_read);
      mem_hit = ~forward_en & mem_wb_en & (src == mem_dest);
      hazard  = use_src & (exe_hit | mem_hit);
   end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer: RAW hazards, taken branches and a memory-wait FSM
// with sticky timeout, plus a saturating stall counter.
module pipeline_control_unit
   import arm_pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             use_src1,
   input  logic             use_src2,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             forward_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_pc,
   output logic             freeze_if2id,
   output logic             flush_if2id,
   output logic             flush_id2exe,
   output logic             freeze_pipe,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic hz1;
   logic hz2;
   logic hazard;
   logic mem_stall;

   mem_state_t        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   hazard_detect u_hz1 (
      .src          (src1),
      .use_src      (use_src1),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .forward_en   (forward_en),
      .hazard       (hz1)
   );

   hazard_detect u_hz2 (
      .src          (src2),
      .use_src      (use_src2),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .forward_en   (forward_en),
      .hazard       (hz2)
   );

   assign hazard    = hz1 | hz2;
   assign mem_stall = mem_req & ~mem_ready;

   // Priority: memory freeze, then branch flush, then hazard stall.
   always_comb begin
      case (state_q)
         M_IDLE, M_WAIT: freeze_pipe = mem_stall;
         M_ERROR:        freeze_pipe = 1'b1;
         default:        freeze_pipe = 1'b0;
      endcase

      freeze_pc    = 1'b0;
      freeze_if2id = 1'b0;
      flush_if2id  = 1'b0;
      flush_id2exe = 1'b0;
      if (!freeze_pipe) begin
         if (branch_taken) begin
            flush_if2id  = 1'b1;
            flush_id2exe = 1'b1;
         end else if (hazard) begin
            freeze_pc    = 1'b1;
            freeze_if2id = 1'b1;
            flush_id2exe = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      case (state_q)
         M_IDLE: begin
            wait_d = '0;
            if (mem_stall) begin
               state_d = M_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         M_WAIT: begin
            if (!mem_req || mem_ready) begin
               state_d = M_IDLE;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               // This edge closes the TIMEOUT-th consecutive frozen cycle.
               state_d   = M_ERROR;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         M_ERROR: begin
         end
         default: begin
            state_d = M_IDLE;
            wait_d  = '0;
         end
      endcase

      stall_d = stall_q;
      if ((freeze_pc || freeze_pipe) && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= M_IDLE;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_count = stall_q;

endmodule
